// File: rtl/block_serializer.sv
// block_serializer: accepts a BYTES x WIDTH block on valid/ready and emits it word 0 first, one word per tick.
// Latency: accept->staged 1 clk, staged->active 1 clk, pending tick->byte_valid_out 1 clk after the emit condition.
// Backpressure: block_ready_out is register-only; tx_busy_in holds emission, one tick may wait, extra ticks are counted as overruns.
// Optional feature macro: BLOCK_SERIALIZER_DOUBLE_BUF_EN (second staging slot so the next block can be taken while streaming).

module block_serializer #(
    parameter int BYTES = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [BYTES*WIDTH-1:0] block_in,
    input  logic                   block_valid_in,
    output logic                   block_ready_out,
    input  logic                   tick_in,
    input  logic                   tx_busy_in,
    output logic [WIDTH-1:0]       byte_out,
    output logic                   byte_valid_out,
    output logic                   last_out,
    output logic                   busy_out,
    output logic [CNT_W-1:0]       overrun_count_out
);

    localparam int BLK_W = BYTES * WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    // IDLE means the active slot is empty; STREAM means it holds a block being emitted
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             emit;
    logic             blk_end;
    logic             load_active;
    logic             stage_full;
    logic [BLK_W-1:0] load_dat;

    logic [BLK_W-1:0] active_q, active_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic [WIDTH-1:0] byte_q, byte_d;
    logic             bvld_q, bvld_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] cur_word;

`ifdef BLOCK_SERIALIZER_DOUBLE_BUF_EN
    logic [BLK_W-1:0] stage_q, stage_d;
    logic             stage_full_q, stage_full_d;

    // Staging slot: filled on accept, released when its block is promoted to active.
    // Accept needs an empty slot and promote needs a full one, so they never coincide.
    always_comb begin
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        if (accept) begin
            stage_d      = block_in;
            stage_full_d = 1'b1;
        end else if (load_active) begin
            stage_full_d = 1'b0;
        end
    end

    // Staging slot registers; contents are discarded on reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stage_q      <= '0;
            stage_full_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
        end
    end

    assign stage_full = stage_full_q;
    assign load_dat   = stage_q;
`else
    // Single slot: the accepted block lands directly in the active register.
    assign stage_full = 1'b0;
    assign load_dat   = block_in;
`endif

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter STREAM on a load, leave only at block end with nothing to load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_active) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (blk_end && !load_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and handshake decode; ready is derived from registers only.
    always_comb begin
        emit    = (state_q == S_STREAM) && pend_q && !tx_busy_in;
        blk_end = emit && (idx_q == LAST_IDX);
`ifdef BLOCK_SERIALIZER_DOUBLE_BUF_EN
        block_ready_out = !stage_full_q;
`else
        block_ready_out = (state_q == S_IDLE);
`endif
        accept = block_valid_in && block_ready_out;
`ifdef BLOCK_SERIALIZER_DOUBLE_BUF_EN
        // Promote into an empty active slot, or back-to-back at block end so no tick is lost.
        load_active = stage_full_q && ((state_q == S_IDLE) || blk_end);
`else
        load_active = accept;
`endif
        busy_out = (state_q == S_STREAM) || stage_full;
    end

    // Word select for the current index.
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_word = active_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Active slot and index: a load restarts at word 0, each emit advances, block end wraps to 0.
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        if (load_active) begin
            active_d = load_dat;
            idx_d    = '0;
        end else if (emit) begin
            idx_d = blk_end ? '0 : idx_q + 1'b1;
        end
    end

    // Pending tick and overrun counter; ticks while idle are ignored entirely.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (state_q == S_IDLE) begin
            pend_d = 1'b0;
        end else if (emit) begin
            // A tick arriving with an emit re-arms the pending flag.
            pend_d = tick_in;
        end else begin
            pend_d = pend_q | tick_in;
            if (tick_in && pend_q && (ovr_q != {CNT_W{1'b1}})) begin
                ovr_d = ovr_q + 1'b1;
            end
        end
    end

    // Registered output stage: strobe for one cycle per emit, word held between strobes.
    always_comb begin
        byte_d = byte_q;
        bvld_d = emit;
        last_d = blk_end;
        if (emit) begin
            byte_d = cur_word;
        end
    end

    // Datapath and output registers; reset drops any active block mid-stream.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active_q <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= '0;
            byte_q   <= '0;
            bvld_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            byte_q   <= byte_d;
            bvld_q   <= bvld_d;
            last_q   <= last_d;
        end
    end

    assign byte_out          = byte_q;
    assign byte_valid_out    = bvld_q;
    assign last_out          = last_q;
    assign overrun_count_out = ovr_q;

    // last_out only ever accompanies a word strobe.
    a_last_with_valid: assert property (@(posedge clk_in) disable iff (!rst_in) last_out |-> byte_valid_out);

    // Nothing is emitted unless a block is active.
    a_emit_needs_stream: assert property (@(posedge clk_in) disable iff (!rst_in) emit |-> (state_q == S_STREAM));

endmodule

// File: tb/tb_block_serializer.sv
// Bench for block_serializer: vector table for the tick/busy/overrun interplay, directed sequences for
// full blocks, busy throttling, counter saturation, asynchronous reset and back-to-back blocks.
module tb_block_serializer;

    localparam int BYTES = 16;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
`ifdef BLOCK_SERIALIZER_DOUBLE_BUF_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [BYTES*WIDTH-1:0] block_in;
    logic                   block_valid_in;
    logic                   block_ready_out;
    logic                   tick_in;
    logic                   tx_busy_in;
    logic [WIDTH-1:0]       byte_out;
    logic                   byte_valid_out;
    logic                   last_out;
    logic                   busy_out;
    logic [CNT_W-1:0]       overrun_count_out;

    block_serializer #(.BYTES(BYTES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .block_in          (block_in),
        .block_valid_in    (block_valid_in),
        .block_ready_out   (block_ready_out),
        .tick_in           (tick_in),
        .tx_busy_in        (tx_busy_in),
        .byte_out          (byte_out),
        .byte_valid_out    (byte_valid_out),
        .last_out          (last_out),
        .busy_out          (busy_out),
        .overrun_count_out (overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       tick;
        logic       busy;
        logic       exp_vld;
        logic [7:0] exp_byte;
        logic       exp_last;
        logic       exp_rdy;
        logic       exp_bsy;
        logic [7:0] exp_ovr;
        string      nm;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 ns after the next edge.
    task automatic step(input logic v, input logic t, input logic b);
        block_valid_in = v;
        tick_in        = t;
        tx_busy_in     = b;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [BYTES*WIDTH-1:0] mk(input logic [7:0] base);
        logic [BYTES*WIDTH-1:0] r;
        for (int k = 0; k < BYTES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(base + k);
        return r;
    endfunction

    // Offer a block until accepted, then one more cycle so it is active in either build.
    task automatic load_block(input logic [BYTES*WIDTH-1:0] blk);
        bit ok;
        ok = 1'b0;
        block_in = blk;
        for (int i = 0; i < 50; i++) begin
            if (block_ready_out) begin
                step(1'b1, 1'b0, 1'b0);
                ok = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        if (!ok) chk("load_accept_timeout", 32'(ok), 32'd1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst_in = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstr;
        int acc_cyc;
        int lasts;
        bit acc_done;
        bit rdy_mid;
        logic [7:0] sb_byte [32];
        logic       sb_last [32];
        int         sb_cyc  [32];

        rst_in = 1'b0;
        block_in = '0;
        block_valid_in = 1'b0;
        tick_in = 1'b0;
        tx_busy_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", 32'(block_ready_out), 32'd1);
        chk("rst_vld", 32'(byte_valid_out), 32'd0);
        chk("rst_byte", 32'(byte_out), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_ovr", 32'(overrun_count_out), 32'd0);
        rst_in = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Vector table: tick/busy interplay on block 0x10..0x1F
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, DB, 1'b1, 8'd0, "pend_set"};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b0, DB, 1'b1, 8'd0, "emit_w0"};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0, DB, 1'b1, 8'd0, "hold_w0"};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b0, DB, 1'b1, 8'd0, "pend_in_busy"};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h10, 1'b0, DB, 1'b1, 8'd0, "busy_blocks"};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b0, DB, 1'b1, 8'd1, "overrun1"};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, DB, 1'b1, 8'd1, "emit_w1"};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, DB, 1'b1, 8'd1, "pend_w2"};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b0, DB, 1'b1, 8'd1, "emit_and_tick"};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b0, DB, 1'b1, 8'd1, "emit_kept_pend"};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h13, 1'b0, DB, 1'b1, 8'd1, "quiet"};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h13, 1'b0, DB, 1'b1, 8'd1, "pend_w4"};

        load_block(mk(8'h10));
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].tick, tbl[i].busy);
            chk({tbl[i].nm, ".vld"},  32'(byte_valid_out),    32'(tbl[i].exp_vld));
            chk({tbl[i].nm, ".byte"}, 32'(byte_out),          32'(tbl[i].exp_byte));
            chk({tbl[i].nm, ".last"}, 32'(last_out),          32'(tbl[i].exp_last));
            chk({tbl[i].nm, ".rdy"},  32'(block_ready_out),   32'(tbl[i].exp_rdy));
            chk({tbl[i].nm, ".bsy"},  32'(busy_out),          32'(tbl[i].exp_bsy));
            chk({tbl[i].nm, ".ovr"},  32'(overrun_count_out), 32'(tbl[i].exp_ovr));
        end

        // Asynchronous reset mid-stream, no clock edge in between
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_vld", 32'(byte_valid_out), 32'd0);
        chk("arst_byte", 32'(byte_out), 32'd0);
        chk("arst_last", 32'(last_out), 32'd0);
        chk("arst_busy", 32'(busy_out), 32'd0);
        chk("arst_ovr", 32'(overrun_count_out), 32'd0);
        chk("arst_ready", 32'(block_ready_out), 32'd1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        nstr = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (c % 4) == 0, 1'b0);
            if (byte_valid_out) nstr++;
        end
        chk("post_rst_no_strobe", 32'(nstr), 32'd0);
        chk("post_rst_ready", 32'(block_ready_out), 32'd1);

        // Full block, free-running ticks, transmitter idle
        load_block(mk(8'h10));
        for (int w = 0; w < BYTES; w++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("t2_w%0d_pre", w), 32'(byte_valid_out), 32'd0);
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("t2_w%0d_vld", w), 32'(byte_valid_out), 32'd1);
            chk($sformatf("t2_w%0d_byte", w), 32'(byte_out), 32'(8'h10 + w));
            chk($sformatf("t2_w%0d_last", w), 32'(last_out), 32'(w == BYTES - 1));
            for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
        end
        chk("t2_end_busy", 32'(busy_out), 32'd0);
        chk("t2_end_ready", 32'(block_ready_out), 32'd1);

        // Busy for three cycles after each strobe, tick lands inside the busy window
        load_block(mk(8'h10));
        for (int w = 0; w < BYTES; w++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("t3_w%0d_held", w), 32'(byte_valid_out), 32'd0);
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("t3_w%0d_vld", w), 32'(byte_valid_out), 32'd1);
            chk($sformatf("t3_w%0d_byte", w), 32'(byte_out), 32'(8'h10 + w));
            chk($sformatf("t3_w%0d_last", w), 32'(last_out), 32'(w == BYTES - 1));
        end
        chk("t3_ovr", 32'(overrun_count_out), 32'd0);
        chk("t3_end_busy", 32'(busy_out), 32'd0);

        // Two ticks during a long busy: one overrun, one word on release
        load_block(mk(8'h10));
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
        chk("t4_ovr1", 32'(overrun_count_out), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_rel_vld", 32'(byte_valid_out), 32'd1);
        chk("t4_rel_byte", 32'(byte_out), 32'h10);
        nstr = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (byte_valid_out) nstr++;
        end
        chk("t4_single_word", 32'(nstr), 32'd0);
        // 300 more ticks under busy: first re-arms, 299 overrun, counter stops at 255
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 253) chk("t4_ovr254", 32'(overrun_count_out), 32'd254);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("t4_ovr_sat", 32'(overrun_count_out), 32'd255);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_rel2_vld", 32'(byte_valid_out), 32'd1);
        chk("t4_rel2_byte", 32'(byte_out), 32'h11);

        // Second block offered while the first streams
        do_reset();
        load_block(mk(8'h10));
        block_in = mk(8'hA0);
        nstr = 0;
        acc_cyc = -1;
        acc_done = 1'b0;
        rdy_mid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic v;
            v = (c >= 5) && !acc_done;
            if (v && block_ready_out) begin
                acc_done = 1'b1;
                acc_cyc = c;
            end
            step(v, (c % 10) == 0, 1'b0);
            if (byte_valid_out && nstr < 32) begin
                sb_byte[nstr] = byte_out;
                sb_last[nstr] = last_out;
                sb_cyc[nstr]  = c;
                nstr++;
            end
            if (nstr >= 1 && nstr <= 14 && block_ready_out) rdy_mid = 1'b1;
            if (nstr == 32) break;
        end
        chk("t5_strobes", 32'(nstr), 32'd32);
        if (nstr == 32) begin
            lasts = 0;
            for (int i = 0; i < 32; i++) begin
                chk($sformatf("t5_s%0d_byte", i), 32'(sb_byte[i]), (i < 16) ? 32'(8'h10 + i) : 32'(8'hA0 + i - 16));
                if (sb_last[i]) lasts++;
            end
            chk("t5_last_count", 32'(lasts), 32'd2);
            chk("t5_last_first", 32'(sb_last[15]), 32'd1);
            chk("t5_last_second", 32'(sb_last[31]), 32'd1);
            chk("t5_gap_boundary", 32'(sb_cyc[16] - sb_cyc[15]), 32'd10);
            chk("t5_accept_before_last", 32'(acc_cyc < sb_cyc[15]), 32'(DB));
        end
        chk("t5_accepted", 32'(acc_done), 32'd1);
        chk("t5_ready_mid_stream", 32'(rdy_mid), 32'(DB));
        chk("t5_end_busy", 32'(busy_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
